// File: rtl/debug_uart_tx_if.sv
// Character stream and status signals shared between the debug producer and the UART transmitter.
interface debug_uart_tx_if #(
  parameter int ASCII_WIDTH = 8,
  parameter int FIFO_DEPTH  = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                   sig;
  logic [ASCII_WIDTH-1:0] ascii;
  logic                   tx;
  logic                   busy;
  logic [LW-1:0]          fifo_level;
  logic                   overflow;

  modport master (
    output sig,
    output ascii,
    input  tx,
    input  busy,
    input  fifo_level,
    input  overflow
  );

  modport slave (
    input  sig,
    input  ascii,
    output tx,
    output busy,
    output fifo_level,
    output overflow
  );
endinterface

// File: rtl/debug_uart_tx.sv
// Buffers strobed debug characters in a small FIFO and serializes them as 8N1 UART frames.
// state | meaning: IDLE tx high, pop when FIFO non-empty | START start bit | DATA LSB-first data bits | STOP stop bit
module debug_uart_tx #(
  parameter int ASCII_WIDTH  = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input logic             clk,
  input logic             res,
  debug_uart_tx_if.slave  dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (ASCII_WIDTH > 1) ? $clog2(ASCII_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [IW-1:0]          bit_q, bit_d;
  logic [ASCII_WIDTH-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [ASCII_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, baud_end;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = dbg.sig && !full;
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == IW'(ASCII_WIDTH - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes together with the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // A strobe into a full FIFO is lost even if the transmitter pops in the same cycle.
  assign ovf_d = ovf_q || (dbg.sig && full);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dbg.ascii;
  end

  assign dbg.tx         = tx_q;
  assign dbg.busy       = (state_q != S_IDLE) || !empty;
  assign dbg.fifo_level = level_q;
  assign dbg.overflow   = ovf_q;

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Downstream consumer of the controller's debugger character stream (debugger_sig / debugger_ascii).
- Each strobed character is buffered in a small FIFO, then serialized as 8N1 UART frames on a single tx line.
- This decouples the CPU's bursty debug prints from the slow serial link. Overflow is reported instead of stalling the core.

Parameters:
- ASCII_WIDTH, 8: character width; also the number of data bits per frame.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 16: character buffer entries. Must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- res  input  1  reset, asynchronous, active-high.
- sig  input  1  character strobe; one character accepted per cycle in which sig=1.
- ascii  input  ASCII_WIDTH  character; sampled when sig=1.
- tx  output  1  UART serial out; idle high.
- busy  output  1  1 while the FIFO is non-empty or a frame is in flight.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky; set when a strobed character is dropped.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, fifo_level=0, overflow=0.
  - FIFO pointers = 0, FSM=IDLE, bit and baud counters = 0.
- Reset mid-frame aborts the frame immediately (tx=1) and discards FIFO contents.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH, plus an occupancy counter.
  - full = (level == FIFO_DEPTH); empty = (level == 0). Both use the registered level at cycle start.
  - Push: sig=1 && !full writes ascii at wptr; wptr++.
  - sig=1 && full: character dropped, overflow<=1. This holds even if a pop occurs that same cycle.
  - overflow is cleared only by reset.
  - Pop: FSM in IDLE && !empty reads rptr into the shift register; rptr++.
  - Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- FSM states IDLE, START, DATA, STOP. A single baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If !empty, pop and go to START with the baud counter cleared.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0]. Each bit is held CLKS_PER_BIT cycles, LSB first; the shift register shifts right at each bit end. After bit ASCII_WIDTH-1 ends, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Frame length is (ASCII_WIDTH+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle (tx=1), i.e. the frame period is (ASCII_WIDTH+2)*CLKS_PER_BIT+1.
  - Latency: sig=1 in cycle N with FIFO empty and FSM idle → pop in cycle N+1 → tx=0 starting cycle N+2.
- tx is driven from a register (glitch-free).
- busy = (state != IDLE) || !empty, derived from registered state.
- sig is level-qualified every cycle. The upstream stage must present one-cycle strobes per character.

Test Plan:
- Single character, CLKS_PER_BIT=4: sig=1 with ascii=0x41 for one cycle → tx low from cycle N+2 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles. busy=1 from N+1 through frame end, then 0.
- Back-to-back: strobe 0x48, 0x69 on consecutive cycles → fifo_level peaks at 1. Two frames are separated by exactly one tx=1 cycle. Total span is 81 cycles at CLKS_PER_BIT=4.
- Overflow, FIFO_DEPTH=4, transmitter busy: strobe 6 characters → one is popped and 4 are buffered, so fifo_level=4. The 6th is dropped and overflow=1. The first 5 characters come out in order; overflow stays 1 after drain.
- Full plus pop same cycle: with level=4, strobe exactly in the IDLE pop cycle → character dropped, overflow=1, level becomes 3.
- Pointer wrap: 40 characters paced one per frame with FIFO_DEPTH=16 → all 40 are received in order by a UART monitor, overflow=0.
- Reset mid-frame: assert res during DATA bit 3 → tx=1, fifo_level=0, busy=0 asynchronously. After release, a new strobe of 0x55 transmits a clean frame.
